// File: rtl/fdc765_pkg.sv
// fdc765_pkg: shared states, opcodes and status constants for the uPD765 stub
package fdc765_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CMD, S_EXEC, S_RESULT} state_t;
  typedef enum logic [2:0] {RC_NONE, RC_ST3, RC_SIS, RC_7B, RC_INV} rclass_t;
  localparam logic [4:0] OP_SPECIFY = 5'h03;
  localparam logic [4:0] OP_SDS = 5'h04;
  localparam logic [4:0] OP_RECAL = 5'h07;
  localparam logic [4:0] OP_SIS = 5'h08;
  localparam logic [4:0] OP_READ_ID = 5'h0A;
  localparam logic [4:0] OP_FORMAT = 5'h0D;
  localparam logic [4:0] OP_SEEK = 5'h0F;
  localparam logic [7:0] MSR_IDLE = 8'h80;
  localparam logic [7:0] MSR_CMD = 8'h90;
  localparam logic [7:0] MSR_EXEC = 8'h10;
  localparam logic [7:0] MSR_RESULT = 8'hD0;
  localparam logic [7:0] ST0_NR = 8'h48;
  localparam logic [7:0] ST0_EC = 8'h58;
  localparam logic [7:0] ST0_INVALID = 8'h80;
  function automatic logic is_xfer(input logic [4:0] op);
    return op inside {5'h02, 5'h05, 5'h06, 5'h09, 5'h0C, 5'h11, 5'h19, 5'h1D};
  endfunction
endpackage

// File: rtl/fdc765_cmd_decode.sv
// fdc765_cmd_decode: opcode to command length and result class
module fdc765_cmd_decode import fdc765_pkg::*; (
  input  logic [4:0] op,
  output logic [3:0] len,
  output rclass_t    rclass
);
  always_comb begin
    len = 4'd1;
    rclass = RC_INV;
    if (is_xfer(op)) begin
      len = 4'd9;
      rclass = RC_7B;
    end else begin
      case (op)
        OP_SPECIFY: begin len = 4'd3; rclass = RC_NONE; end
        OP_SDS: begin len = 4'd2; rclass = RC_ST3; end
        OP_RECAL: begin len = 4'd2; rclass = RC_NONE; end
        OP_SEEK: begin len = 4'd3; rclass = RC_NONE; end
        OP_SIS: rclass = RC_SIS;
        OP_READ_ID: begin len = 4'd2; rclass = RC_7B; end
        OP_FORMAT: begin len = 4'd6; rclass = RC_7B; end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/fdc765_stub.sv
// fdc765_stub: uPD765 host-side protocol with no media attached; every drive reports not ready
module fdc765_stub import fdc765_pkg::*; #(
  parameter int EXEC_CYCLES = 64,
  parameter int NDRIVES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        oe_n,
  output logic        motor_on,
  output logic        int_pending
);
  localparam int CW = $clog2(EXEC_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(EXEC_CYCLES - 1);
  state_t state, state_n;
  rclass_t dec_rc;
  logic [CW-1:0] cnt;
  logic [7:0] cmd [9];
  logic [7:0] res [7];
  logic [7:0] res_n [7];
  logic [3:0] bidx, cmd_len, dec_len;
  logic [2:0] idx, res_len, res_len_n;
  logic [7:0] din_q, st0_q, pcn_q, st0, st3, msr;
  logic [4:0] op;
  logic sel, wr_mot, rd_msr, rd_dat, wr_dat, wr_mot_q, rd_dat_q, wr_dat_q;
  logic wr_mot_end, rd_dat_end, wr_dat_end, unit_ok, exec_done, unused_a;
  assign sel = !iorq_n && !a[1];
  assign wr_mot = sel && a[15:12] == 4'h1 && !wr_n;
  assign rd_msr = sel && a[15:12] == 4'h2 && !rd_n;
  assign rd_dat = sel && a[15:12] == 4'h3 && !rd_n;
  assign wr_dat = sel && a[15:12] == 4'h3 && !wr_n;
  assign unused_a = ^{a[11:2], a[0]};
  // actions fire once, on the clock where the strobe has just gone away
  assign wr_mot_end = wr_mot_q && !wr_mot;
  assign rd_dat_end = rd_dat_q && !rd_dat;
  assign wr_dat_end = wr_dat_q && !wr_dat;
  assign oe_n = !(rd_msr || rd_dat);
  assign msr = state == S_IDLE ? MSR_IDLE : state == S_CMD ? MSR_CMD :
               state == S_EXEC ? MSR_EXEC : MSR_RESULT;
  assign dout = !rd_dat ? msr : state == S_RESULT ? res[idx] : 8'hFF;
  assign op = state == S_IDLE ? din_q[4:0] : cmd[0][4:0];
  assign unit_ok = int'(cmd[1][1:0]) < NDRIVES;
  assign st0 = (unit_ok ? ST0_NR : ST0_EC) | {5'd0, cmd[1][2:0]};
  assign st3 = {3'd0, unit_ok, 1'b0, cmd[1][2:0]};
  assign exec_done = state == S_EXEC && cnt == '0;
  fdc765_cmd_decode u_dec (.op(op), .len(dec_len), .rclass(dec_rc));
  always_comb begin
    res_n = '{default: 8'h00};
    res_n[0] = ST0_INVALID;
    res_len_n = 3'd1;
    case (dec_rc)
      RC_NONE: res_len_n = 3'd0;
      RC_ST3: res_n[0] = st3;
      RC_SIS: if (int_pending) begin
        res_n[0] = st0_q;
        res_n[1] = pcn_q;
        res_len_n = 3'd2;
      end
      RC_7B: begin
        res_len_n = 3'd7;
        res_n[0] = st0;
        res_n[3] = op == OP_READ_ID ? 8'h00 : cmd[2];
        res_n[4] = is_xfer(op) ? cmd[3] : 8'h00;
        res_n[5] = is_xfer(op) ? cmd[4] : 8'h00;
        res_n[6] = is_xfer(op) ? cmd[5] : 8'h00;
      end
      default: ;
    endcase
  end
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (wr_dat_end) state_n = dec_len == 4'd1 ? S_EXEC : S_CMD;
      S_CMD: if (wr_dat_end && bidx == cmd_len - 4'd1) state_n = S_EXEC;
      S_EXEC: if (cnt == '0) state_n = res_len_n == 3'd0 ? S_IDLE : S_RESULT;
      default: if (rd_dat_end && idx == res_len - 3'd1) state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      idx <= '0;
      bidx <= '0;
      cmd_len <= 4'd1;
      res_len <= '0;
      motor_on <= 1'b0;
      int_pending <= 1'b0;
      st0_q <= '0;
      pcn_q <= '0;
      din_q <= '0;
      wr_mot_q <= 1'b0;
      rd_dat_q <= 1'b0;
      wr_dat_q <= 1'b0;
    end else begin
      state <= state_n;
      wr_mot_q <= wr_mot;
      rd_dat_q <= rd_dat;
      wr_dat_q <= wr_dat;
      if (wr_mot || wr_dat) din_q <= din;
      if (wr_mot_end) motor_on <= din_q[3];
      if (state_n == S_EXEC && state != S_EXEC) cnt <= CNT_LOAD;
      else if (state == S_EXEC && cnt != '0) cnt <= cnt - CW'(1);
      if (state == S_IDLE && wr_dat_end) begin
        cmd_len <= dec_len;
        bidx <= 4'd1;
      end else if (state == S_CMD && wr_dat_end) bidx <= bidx + 4'd1;
      if (exec_done) begin
        res_len <= res_len_n;
        idx <= '0;
        if (op == OP_RECAL || op == OP_SEEK) begin
          int_pending <= 1'b1;
          st0_q <= st0;
          pcn_q <= op == OP_SEEK ? cmd[2] : 8'h00;
        end else if (dec_rc == RC_SIS) int_pending <= 1'b0;
      end
      if (state == S_RESULT && rd_dat_end) idx <= state_n == S_IDLE ? 3'd0 : idx + 3'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_dat_end && (state == S_IDLE || state == S_CMD)) cmd[state == S_IDLE ? 4'd0 : bidx] <= din_q;
    if (exec_done) res <= res_n;
  end
endmodule

// File: tb/tb_fdc765_stub.sv
// tb_fdc765_stub: scoreboard bench; stimulus queues expectations, monitors pop on reads and snapshots
module tb_fdc765_stub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [15:0] a = '0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic oe_n, motor_on, int_pending;
  typedef struct {logic is_rd; logic [10:0] v; string n;} exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  bit rd_seen = 1'b0;
  event snap_ev;
  localparam logic [15:0] MOT = 16'h1FFD, MSR = 16'h2FFD, DAT = 16'h3FFD;
  logic [7:0] rd_cmd [9] = '{8'h46, 8'h01, 8'h05, 8'h00, 8'h03, 8'h02, 8'h09, 8'h2A, 8'hFF};
  logic [7:0] rd_res [7] = '{8'h59, 8'h00, 8'h00, 8'h05, 8'h00, 8'h03, 8'h02};

  fdc765_stub #(.EXEC_CYCLES(64), .NDRIVES(1)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .din(din), .dout(dout), .oe_n(oe_n), .motor_on(motor_on), .int_pending(int_pending)
  );

  always #5 clk = ~clk;

  task automatic compare(input logic is_rd, input logic [10:0] got);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s got=%h", is_rd ? "read" : "snap", got);
    end else begin
      e = q.pop_front();
      if (e.is_rd != is_rd || e.v != got) begin
        failures++;
        $display("FAIL %s got=%h expected=%h", e.n, got, e.v);
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!oe_n && !rd_seen) compare(1'b1, {3'b000, dout});
    rd_seen = !oe_n;
  end

  always @(snap_ev) compare(1'b0, {dout, motor_on, int_pending, oe_n});

  task automatic push(input logic r, input logic [10:0] v, input string n);
    exp_t e;
    e.is_rd = r;
    e.v = v;
    e.n = n;
    q.push_back(e);
  endtask

  task automatic bus(input logic r, input logic [15:0] ad, input logic [7:0] d, input int hold, input logic oe_chk);
    @(negedge clk);
    a = ad;
    din = d;
    iorq_n = 1'b0;
    rd_n = !r;
    wr_n = r;
    if (oe_chk) begin
      #1;
      ->snap_ev;
    end
    repeat (hold) @(negedge clk);
    iorq_n = 1'b1;
    rd_n = 1'b1;
    wr_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] ad, input logic [7:0] d, input int hold);
    bus(1'b0, ad, d, hold, 1'b0);
  endtask

  task automatic rd(input logic [15:0] ad, input logic [7:0] e, input string n, input int hold);
    push(1'b1, {3'b000, e}, n);
    bus(1'b1, ad, 8'h00, hold, 1'b0);
  endtask

  task automatic stat(input logic [7:0] d, input logic m, input logic ip, input logic oe, input string n);
    #1;
    push(1'b0, {d, m, ip, oe}, n);
    ->snap_ev;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    stat(8'h80, 0, 0, 1, "reset_state");
    @(negedge clk) rst_n = 1'b1;
    idle(1);
    push(1'b0, {8'h80, 3'b000}, "oe_low_msr");
    push(1'b1, {3'b000, 8'h80}, "msr_idle");
    bus(1'b1, MSR, 8'h00, 1, 1'b1);
    wr(MSR, 8'h55, 1);
    stat(8'h80, 0, 0, 1, "msr_write_ignored");
    wr(DAT, 8'h07, 1);
    stat(8'h90, 0, 0, 1, "recal_cmd");
    wr(DAT, 8'h00, 1);
    stat(8'h10, 0, 0, 1, "exec_first");
    idle(63);
    stat(8'h10, 0, 0, 1, "exec_last");
    idle(1);
    stat(8'h80, 0, 1, 1, "exec_done");
    wr(DAT, 8'h08, 1);
    idle(70);
    stat(8'hD0, 0, 0, 1, "sis_result");
    rd(DAT, 8'h48, "sis_st0_held", 20);
    rd(DAT, 8'h00, "sis_pcn", 1);
    stat(8'h80, 0, 0, 1, "sis_done");
    wr(DAT, 8'h08, 1);
    idle(70);
    rd(DAT, 8'h80, "sis_noint", 1);
    stat(8'h80, 0, 0, 1, "sis_noint_done");
    wr(DAT, 8'h1F, 1);
    idle(70);
    rd(DAT, 8'h80, "invalid_op", 1);
    stat(8'h80, 0, 0, 1, "invalid_done");
    wr(DAT, rd_cmd[0], 1);
    rd(MSR, 8'h90, "read_data_cmd_msr", 1);
    for (int i = 1; i < 9; i++) wr(DAT, rd_cmd[i], 1);
    idle(70);
    foreach (rd_res[i]) rd(DAT, rd_res[i], $sformatf("read_data_res%0d", i), 1);
    stat(8'h80, 0, 0, 1, "read_data_done");
    wr(DAT, 8'h04, 1);
    wr(DAT, 8'h00, 1);
    idle(70);
    rd(DAT, 8'h10, "st3_ready_unit", 1);
    wr(DAT, 8'h04, 1);
    wr(DAT, 8'h01, 1);
    idle(70);
    rd(DAT, 8'h01, "st3_absent_unit", 1);
    wr(MOT, 8'hFF, 1);
    stat(8'h80, 1, 0, 1, "motor_on");
    wr(MOT, 8'h00, 1);
    stat(8'h80, 0, 0, 1, "motor_off");
    rd(DAT, 8'hFF, "idle_data_read", 1);
    stat(8'h80, 0, 0, 1, "idle_read_no_change");
    wr(DAT, 8'h0F, 1);
    wr(DAT, 8'h00, 1);
    wr(DAT, 8'h22, 1);
    idle(70);
    stat(8'h80, 0, 1, 1, "seek1_pending");
    wr(DAT, 8'h0F, 1);
    wr(DAT, 8'h01, 1);
    wr(DAT, 8'h33, 1);
    idle(70);
    wr(DAT, 8'h08, 1);
    idle(70);
    rd(DAT, 8'h59, "overwrite_st0", 1);
    rd(DAT, 8'h33, "overwrite_pcn", 1);
    wr(DAT, 8'h07, 1);
    wr(DAT, 8'h00, 1);
    idle(70);
    wr(DAT, 8'h0F, 1);
    wr(DAT, 8'h00, 1);
    stat(8'h90, 0, 1, 1, "seek_partial");
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    stat(8'h80, 0, 0, 1, "reset_mid_seek");
    wr(DAT, 8'h03, 20);
    stat(8'h90, 0, 0, 1, "held_write_once");
    wr(DAT, 8'hDF, 1);
    stat(8'h90, 0, 0, 1, "specify_byte2");
    wr(DAT, 8'h03, 1);
    stat(8'h10, 0, 0, 1, "specify_exec");
    idle(70);
    stat(8'h80, 0, 0, 1, "specify_no_result");
    idle(4);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL pending_expectations got=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
